fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and next-PC unit for the single-cycle MIPS core.
- Owns the PC and fetches instruction words over a req/ack instruction-memory port.
- Presents each instruction (opcode field Inst_31_26 feeds CONTROL) and waits for the core to accept it.
- On acceptance, consumes CONTROL's Branch/Branch_Not_Equal/Jump outputs, plus ALU Zero and a jr request, to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- FETCH_TIMEOUT, 16, max cycles waiting for imem_ack before flagging fetch_error

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request, held until ack
- imem_addr  output  32  fetch address (= PC)
- imem_ack  input  1  memory response valid
- imem_rdata  input  32  instruction word, valid with imem_ack
- inst  output  32  registered current instruction
- inst_valid  output  1  inst holds an instruction awaiting execution
- inst_ready  input  1  core executes/accepts inst this cycle
- pc  output  32  address of inst
- pc_plus4  output  32  pc + 4, used as jal link value
- Branch  input  1  beq from CONTROL
- Branch_Not_Equal  input  1  bne from CONTROL
- Jump  input  1  j/jal from CONTROL
- Zero  input  1  ALU zero flag
- Jump_Reg  input  1  jr decoded by ALU control
- jr_target  input  32  rs value for jr
- fetch_error  output  1  sticky: timeout or misaligned jr target

Behaviour:
- Reset (asynchronous, any state):
  - state=FETCH, PC=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_error=0, timeout counter=0.
  - imem_req rises on the first clk edge after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=PC; timeout counter increments each cycle.
    - On imem_ack: inst<=imem_rdata, counter<=0, go ISSUE.
    - Ack in the same cycle req first rises is valid.
  - ISSUE: inst_valid=1, imem_req=0; imem_ack is ignored.
    - On inst_ready: PC<=next_pc, inst_valid<=0 next cycle, go FETCH.
    - Without inst_ready: hold inst and PC indefinitely.
  - HALT: entered when the counter reaches FETCH_TIMEOUT with no ack.
    - fetch_error=1, imem_req=0, inst_valid=0.
    - Exit only by reset.
- next_pc, evaluated combinationally in ISSUE, in priority order:
  1. Jump_Reg: {jr_target[31:2],2'b00}. If jr_target[1:0]!=0, set fetch_error (sticky) but continue.
  2. Jump: {pc_plus4[31:28], inst[25:0], 2'b00}.
  3. (Branch & Zero) | (Branch_Not_Equal & ~Zero): pc_plus4 + ({{14{inst[15]}},inst[15:0],2'b00}), modulo 2^32.
  4. Otherwise pc_plus4.
- Arithmetic: all adds are 32-bit and wrap; PC 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Latency: with a zero-wait memory (ack same cycle as req), one instruction per 2 cycles (FETCH, ISSUE). Each extra wait cycle adds 1.
- Control inputs are sampled only in ISSUE when inst_ready=1; they are don't-care otherwise.
- Branch and Branch_Not_Equal both high: taken if either condition holds (cannot occur with CONTROL; defined for robustness).
- imem_rdata with bits X during FETCH without ack: not captured.

Test Plan:
- Reset with RESET_PC=0x100, memory acks every req with 0x20080005 (addi), inst_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; inst_valid high every second cycle; fetch_error=0.
- beq at pc=0x200 with inst[15:0]=0xFFFE, Branch=1, Zero=1 -> next imem_addr=0x1FC. Same instruction with Zero=0 -> next imem_addr=0x204.
- jal at pc=0x4000_0010 with inst=0x0C000040, Jump=1 -> pc_plus4=0x4000_0014, next imem_addr=0x4000_0100.
- jr with Jump_Reg=1 and Jump=1, jr_target=0x0000_0123 -> next imem_addr=0x120 (Jump_Reg wins), fetch_error=1 sticky.
- Hold inst_ready=0 for 5 cycles in ISSUE -> inst, pc, and inst_valid stable, imem_req=0. Then assert reset mid-FETCH -> all outputs return to reset values immediately, without waiting for a clk edge.
- Never assert imem_ack -> after 16 FETCH cycles fetch_error=1, imem_req=0, state HALT. Also: PC=0xFFFF_FFFC, non-branch instruction -> next imem_addr=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC selection for the single-cycle MIPS core.
// Fetches over a req/ack port, holds each word until the core accepts it, then steers the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Branch_Not_Equal,
  input  logic        Jump,
  input  logic        Zero,
  input  logic        Jump_Reg,
  input  logic [31:0] jr_target,
  output logic        fetch_error
);

  localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      inst_q, inst_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      next_pc;
  logic [31:0]      br_off;
  logic             br_taken;

  // Next-PC candidates in priority order: jr, j/jal, taken branch, sequential.
  always_comb begin
    br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    br_taken = (Branch & Zero) | (Branch_Not_Equal & ~Zero);
    if (Jump_Reg)      next_pc = {jr_target[31:2], 2'b00};
    else if (Jump)     next_pc = {pc4_q[31:28], inst_q[25:0], 2'b00};
    else if (br_taken) next_pc = pc4_q + br_off;
    else               next_pc = pc4_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first FETCH cycle after reset only raises the request; acks count once it is visible.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          cnt_d   = '0;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          pc_d    = next_pc;
          pc4_d   = next_pc + 32'd4;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
          if (Jump_Reg && (jr_target[1:0] != 2'b00)) err_d = 1'b1;
        end
      end
      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign inst_valid  = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc4_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction streams
// checked against a next-PC reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch = 1'b0;
  logic        Branch_Not_Equal = 1'b0;
  logic        Jump = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump_Reg = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        fetch_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;
  logic        model_err;

  fetch_unit #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .Branch(Branch), .Branch_Not_Equal(Branch_Not_Equal), .Jump(Jump), .Zero(Zero),
    .Jump_Reg(Jump_Reg), .jr_target(jr_target), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  // Reference next-PC from the instruction-set rules using plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic br, input logic bne, input logic jmp,
                                           input logic z, input logic jreg, input logic [31:0] jt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    if (jreg) return jt & 32'hFFFF_FFFC;
    if (jmp) return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
    if ((br && z) || (bne && !z)) return seq + 32'(off);
    return seq;
  endfunction

  task automatic randomize_ctrl();
    Branch = 1'($urandom); Branch_Not_Equal = 1'($urandom); Jump = 1'($urandom);
    Zero = 1'($urandom); Jump_Reg = 1'($urandom); jr_target = $urandom;
  endtask

  // Reset asserted for two edges, released at a negedge; request must appear one edge later.
  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== RST_PC || pc_plus4 !== RST_PC + 32'd4 || inst !== 32'd0 || inst_valid !== 1'b0 ||
        imem_req !== 1'b0 || fetch_error !== 1'b0)
      begin errors++; $display("FAIL reset_values: pc=%h pc4=%h inst=%h v=%b req=%b err=%b",
                               pc, pc_plus4, inst, inst_valid, imem_req, fetch_error); end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL req_before_edge: got %b want 0", imem_req); end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      begin errors++; $display("FAIL first_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC); end
    model_pc = RST_PC;
    model_err = 1'b0;
  endtask

  // One fetch/issue round trip; entered and left at a negedge with the DUT in FETCH.
  task automatic do_inst(input logic [31:0] word, input int waits, input int holds,
                         input logic br, input logic bne, input logic jmp, input logic z,
                         input logic jreg, input logic [31:0] jt);
    logic [31:0] exp_next;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc)
      begin errors++; $display("FAIL fetch_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, model_pc); end
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== model_pc)
        begin errors++; $display("FAIL fetch_wait: req=%b v=%b addr=%h", imem_req, inst_valid, imem_addr); end
    end
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    checks++;
    if (inst_valid !== 1'b1 || inst !== word || pc !== model_pc || pc_plus4 !== model_pc + 32'd4 ||
        imem_req !== 1'b0)
      begin errors++; $display("FAIL issue: v=%b inst=%h pc=%h pc4=%h req=%b want inst=%h pc=%h",
                               inst_valid, inst, pc, pc_plus4, imem_req, word, model_pc); end
    for (int h = 0; h < holds; h++) begin
      randomize_ctrl();
      imem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst !== word || pc !== model_pc || imem_req !== 1'b0 ||
          fetch_error !== model_err)
        begin errors++; $display("FAIL hold: v=%b inst=%h pc=%h req=%b err=%b want inst=%h pc=%h",
                                 inst_valid, inst, pc, imem_req, fetch_error, word, model_pc); end
    end
    imem_ack = 1'b0;
    Branch = br; Branch_Not_Equal = bne; Jump = jmp; Zero = z; Jump_Reg = jreg; jr_target = jt;
    inst_ready = 1'b1;
    exp_next = ref_next(model_pc, word, br, bne, jmp, z, jreg, jt);
    if (jreg && (jt % 4 != 0)) model_err = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    randomize_ctrl();
    model_pc = exp_next;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_next || inst_valid !== 1'b0 || fetch_error !== model_err)
      begin errors++; $display("FAIL next_pc: addr=%h req=%b v=%b err=%b want %h 1 0 %b",
                               imem_addr, imem_req, inst_valid, fetch_error, exp_next, model_err); end
  endtask

  task automatic goto_pc(input logic [31:0] target);
    do_inst(32'h0000_0008, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, target);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) do_inst(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0000_010C || fetch_error !== 1'b0)
      begin errors++; $display("FAIL seq_addr: addr=%h err=%b want 0000010c 0", imem_addr, fetch_error); end
  endtask

  task automatic test_branch();
    goto_pc(32'h0000_0200);
    do_inst(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0000_01FC) begin errors++; $display("FAIL beq_taken: got %h want 000001fc", imem_addr); end
    goto_pc(32'h0000_0200);
    do_inst(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0000_0204) begin errors++; $display("FAIL beq_not_taken: got %h want 00000204", imem_addr); end
    do_inst(32'h1400_0003, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0000_0214) begin errors++; $display("FAIL both_branch: got %h want 00000214", imem_addr); end
  endtask

  task automatic test_jal();
    goto_pc(32'h4000_0010);
    imem_ack = 1'b1; imem_rdata = 32'h0C00_0040;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (pc_plus4 !== 32'h4000_0014) begin errors++; $display("FAIL jal_link: got %h want 40000014", pc_plus4); end
    Jump = 1'b1; Jump_Reg = 1'b0; Branch = 1'b0; Branch_Not_Equal = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    model_pc = 32'h4000_0100;
    checks++;
    if (imem_addr !== 32'h4000_0100) begin errors++; $display("FAIL jal_target: got %h want 40000100", imem_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] jt;
      jt = $urandom;
      if ($urandom_range(7) != 0) jt = jt & 32'hFFFF_FFFC;
      do_inst($urandom, int'($urandom_range(3)), int'($urandom_range(2)), 1'($urandom), 1'($urandom),
              ($urandom_range(3) == 0), 1'($urandom), ($urandom_range(4) == 0), jt);
    end
  endtask

  task automatic test_jr_misaligned();
    do_inst(32'h0080_0008, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0123);
    checks++;
    if (imem_addr !== 32'h0000_0120 || fetch_error !== 1'b1)
      begin errors++; $display("FAIL jr_misaligned: addr=%h err=%b want 00000120 1", imem_addr, fetch_error); end
    do_inst(32'h2008_0005, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (fetch_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", fetch_error); end
  endtask

  task automatic test_hold_and_async_reset();
    do_inst(32'h2008_0007, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    imem_ack = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pc !== RST_PC || inst !== 32'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || fetch_error !== 1'b0)
      begin errors++; $display("FAIL async_reset: pc=%h inst=%h v=%b req=%b err=%b",
                               pc, inst, inst_valid, imem_req, fetch_error); end
    do_reset();
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    do_inst(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_error !== 1'b0)
        begin errors++; $display("FAIL timeout_wait%0d: req=%b err=%b want 1 0", i, imem_req, fetch_error); end
      @(negedge clk);
    end
    checks++;
    if (imem_req !== 1'b0 || fetch_error !== 1'b1 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL timeout_halt: req=%b err=%b v=%b want 0 1 0", imem_req, fetch_error, inst_valid); end
    imem_ack = 1'b1; inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0; inst_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || fetch_error !== 1'b1 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL halt_stays: req=%b err=%b v=%b", imem_req, fetch_error, inst_valid); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_random();
    test_jr_misaligned();
    test_hold_and_async_reset();
    test_wrap();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
